// File: rtl/channel_merge_rr.sv
// M-way round-robin merge of valid/acknowledge channels onto one registered output,
// with optional burst lock and a source-index tag on the output data.
module channel_merge_rr #(
    parameter int unsigned N        = 8,
    parameter int unsigned M        = 4,
    parameter int unsigned MaxBurst = 1,
    parameter int unsigned TagEn    = 1,
    localparam int unsigned IdxW    = $clog2(M),
    localparam int unsigned OutW    = N + TagEn * IdxW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [M*N-1:0]    in_d,
    input  logic [M-1:0]      in_v,
    output logic [M-1:0]      in_a,
    output logic [OutW-1:0]   out_d,
    output logic              out_v,
    input  logic              out_a,
    output logic [IdxW-1:0]   grant
);

    localparam int unsigned BurstW = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;

    logic [IdxW-1:0]   last_q, last_d;
    logic [BurstW-1:0] burst_q, burst_d;
    logic              started_q, started_d;
    logic [OutW-1:0]   out_d_q, out_d_d;
    logic              out_v_q, out_v_d;

    logic [IdxW-1:0]   sel;
    logic [N-1:0]      sel_data;
    logic [2*M-1:0]    v_rot;
    logic              load;
    logic              lock;
    logic              found;
    logic              xfer;
    logic              burst_room;

    assign load       = ~out_v_q | out_a;
    assign burst_room = 32'(burst_q) < (MaxBurst - 32'd1);

    // Arbiter: burst lock on the last winner, otherwise first valid after last.
    always_comb begin : arb
        int unsigned cand;
        cand  = 0;
        lock  = 1'b0;
        found = 1'b0;
        sel   = last_q;
        v_rot = {in_v, in_v} >> (32'(last_q) + 32'd1);
        if ((MaxBurst > 1) && started_q && in_v[last_q] && burst_room) begin
            lock = 1'b1;
        end
        if (!lock) begin
            for (int unsigned k = 0; k < M; k++) begin
                cand = 32'(last_q) + 32'd1 + k;
                if (cand >= M) begin
                    cand = cand - M;
                end
                if (!found && v_rot[k]) begin
                    found = 1'b1;
                    sel   = IdxW'(cand);
                end
            end
        end
    end

    always_comb begin : data_mux
        sel_data = '0;
        for (int unsigned i = 0; i < M; i++) begin
            if (sel == IdxW'(i)) begin
                sel_data = in_d[i*N +: N];
            end
        end
    end

    // Acknowledge only the selected, valid input when the output can take it.
    always_comb begin : ack
        in_a = '0;
        for (int unsigned i = 0; i < M; i++) begin
            in_a[i] = (sel == IdxW'(i)) & in_v[i] & load & ~reset;
        end
    end

    assign xfer  = |in_a;
    assign grant = reset ? '0 : sel;

    always_comb begin : next_state
        last_d    = last_q;
        burst_d   = burst_q;
        started_d = started_q;
        out_d_d   = out_d_q;
        out_v_d   = out_v_q;
        if (xfer) begin
            out_d_d   = OutW'({sel, sel_data});
            out_v_d   = 1'b1;
            last_d    = sel;
            started_d = 1'b1;
            if (sel == last_q) begin
                // Saturate: once the limit is reached the lock is already off.
                burst_d = burst_room ? burst_q + BurstW'(1) : burst_q;
            end else begin
                burst_d = '0;
            end
        end else if (out_a) begin
            out_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin : regs
        if (reset) begin
            last_q    <= IdxW'(M - 1);
            burst_q   <= '0;
            started_q <= 1'b0;
            out_d_q   <= '0;
            out_v_q   <= 1'b0;
        end else begin
            last_q    <= last_d;
            burst_q   <= burst_d;
            started_q <= started_d;
            out_d_q   <= out_d_d;
            out_v_q   <= out_v_d;
        end
    end

    assign out_d = out_d_q;
    assign out_v = out_v_q;

endmodule

// File: tb/tb_channel_merge_rr.sv
// Directed and randomised checks of channel_merge_rr: pure round-robin instance
// plus a MaxBurst=3 instance for burst-lock ordering.
module tb_channel_merge_rr;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_d;
    logic [3:0]  in_v;
    logic [3:0]  in_a;
    logic [9:0]  out_d;
    logic        out_v;
    logic        out_a;
    logic [1:0]  grant;

    logic [31:0] in_d3;
    logic [3:0]  in_v3;
    logic [3:0]  in_a3;
    logic [9:0]  out_d3;
    logic        out_v3;
    logic        out_a3;
    logic [1:0]  grant3;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    channel_merge_rr #(.N(8), .M(4), .MaxBurst(1), .TagEn(1)) u_dut (
        .clk(clk), .reset(reset), .in_d(in_d), .in_v(in_v), .in_a(in_a),
        .out_d(out_d), .out_v(out_v), .out_a(out_a), .grant(grant)
    );

    channel_merge_rr #(.N(8), .M(4), .MaxBurst(3), .TagEn(1)) u_dut3 (
        .clk(clk), .reset(reset), .in_d(in_d3), .in_v(in_v3), .in_a(in_a3),
        .out_d(out_d3), .out_v(out_v3), .out_a(out_a3), .grant(grant3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] exp_out(input int idx, input logic [7:0] d);
        return {2'(idx), d};
    endfunction

    function automatic logic [7:0] pat(input int idx);
        return 8'(8'hA0 + idx);
    endfunction

    int t3_seq [20] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0, 1, 2, 2, 2, 3};

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int          seq [4];
        int          wait_cnt [4];
        int          max_wait;
        int          sel_i;
        int          e;
        logic        mv;
        logic        load_m;
        logic [3:0]  acc;

        reset  = 1'b1;
        in_v   = '0;
        in_d   = '0;
        out_a  = 1'b0;
        in_v3  = '0;
        in_d3  = '0;
        out_a3 = 1'b0;

        // Reset state
        #1;
        check_eq("rst_out_v", 32'(out_v), 0);
        check_eq("rst_out_d", 32'(out_d), 0);
        check_eq("rst_grant", 32'(grant), 0);
        in_v  = 4'hF;
        in_d  = {pat(3), pat(2), pat(1), pat(0)};
        out_a = 1'b1;
        #1;
        check_eq("rst_in_a", 32'(in_a), 0);

        // T1: all valid, pure round-robin 0,1,2,3,0,1
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            e = c % 4;
            #1;
            check_eq("t1_grant", 32'(grant), 32'(e));
            check_eq("t1_in_a", 32'(in_a), 32'(1) << e);
            @(posedge clk); #1;
            check_eq("t1_out_v", 32'(out_v), 1);
            check_eq("t1_out_d", 32'(out_d), 32'(exp_out(e, pat(e))));
        end

        // T2: only input 2 valid, back-to-back transfers
        in_v = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            #1;
            check_eq("t2_in_a", 32'(in_a), 32'h4);
            @(posedge clk); #1;
            check_eq("t2_out_v", 32'(out_v), 1);
            check_eq("t2_out_d", 32'(out_d), 32'(exp_out(2, pat(2))));
        end

        // T4: backpressure holds output, no acks, then resumes after saved last
        in_v = 4'hF;
        #1;
        check_eq("t4_grant_pre", 32'(grant), 3);
        @(posedge clk); #1;
        check_eq("t4_out_d_pre", 32'(out_d), 32'(exp_out(3, pat(3))));
        out_a = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check_eq("t4_stall_in_a", 32'(in_a), 0);
            @(posedge clk); #1;
            check_eq("t4_stall_out_v", 32'(out_v), 1);
            check_eq("t4_stall_out_d", 32'(out_d), 32'(exp_out(3, pat(3))));
        end
        out_a = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            check_eq("t4_resume_grant", 32'(grant), 32'(c));
            @(posedge clk); #1;
            check_eq("t4_resume_out_d", 32'(out_d), 32'(exp_out(c, pat(c))));
        end

        // T5: async reset between edges, first grant afterwards goes to input 0
        #2;
        reset = 1'b1;
        #1;
        check_eq("t5_out_v", 32'(out_v), 0);
        check_eq("t5_out_d", 32'(out_d), 0);
        check_eq("t5_in_a", 32'(in_a), 0);
        @(posedge clk); #1;
        check_eq("t5_hold_out_v", 32'(out_v), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("t5_first_grant", 32'(grant), 0);
        check_eq("t5_first_in_a", 32'(in_a), 1);
        @(posedge clk); #1;
        check_eq("t5_first_out_d", 32'(out_d), 32'(exp_out(0, pat(0))));

        // T3: MaxBurst=3 ordering, input 1 drops after its first grant of the round
        in_v3  = 4'hF;
        in_d3  = {pat(3), pat(2), pat(1), pat(0)};
        out_a3 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            check_eq("t3_grant", 32'(grant3), 32'(t3_seq[c]));
            @(posedge clk); #1;
            check_eq("t3_out_v", 32'(out_v3), 1);
            check_eq("t3_out_d", 32'(out_d3), 32'(exp_out(t3_seq[c], pat(t3_seq[c]))));
            if (c == 15) begin
                in_v3[1] = 1'b0;
            end
        end

        // T6: random valid/acknowledge with per-input sequence scoreboard
        reset = 1'b1;
        in_v  = '0;
        in_d  = '0;
        #3;
        @(negedge clk);
        reset    = 1'b0;
        mv       = 1'b0;
        max_wait = 0;
        for (int i = 0; i < 4; i++) begin
            seq[i]      = 0;
            wait_cnt[i] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!in_v[i] && ($urandom_range(0, 1) == 1)) begin
                    in_v[i]         = 1'b1;
                    in_d[i*8 +: 8]  = 8'(seq[i]);
                end
            end
            out_a = ($urandom_range(0, 3) != 0);
            #1;
            load_m = !mv || out_a;
            acc    = in_a;
            check_eq("t6_onehot0", 32'($onehot0(acc)), 1);
            check_eq("t6_ack_no_valid", 32'(acc & ~in_v), 0);
            check_eq("t6_ack_when_able", 32'(acc != 0), 32'(load_m && (in_v != 0)));
            sel_i = 0;
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) sel_i = i;
                if (in_v[i]) begin
                    if (acc[i]) wait_cnt[i] = 0;
                    else if (acc != 0) wait_cnt[i]++;
                    if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                end
            end
            @(posedge clk); #1;
            if (acc != 0) begin
                mv = 1'b1;
                check_eq("t6_out_d", 32'(out_d), 32'(exp_out(sel_i, 8'(seq[sel_i]))));
                seq[sel_i]++;
                in_v[sel_i] = ($urandom_range(0, 1) == 1);
                in_d[sel_i*8 +: 8] = 8'(seq[sel_i]);
            end else if (out_a) begin
                mv = 1'b0;
            end
            check_eq("t6_out_v", 32'(out_v), 32'(mv));
        end
        check_eq("t6_fair_wait", 32'(max_wait <= 4), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
